// File: rtl/alu_seq_ctrl.sv
// Instruction sequencer and 4x4-bit operand register file for the serial ALU core.
// Optional ALU_SEQ_FLAGS_EN adds carry/zero flag outputs captured at writeback.
module alu_seq_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [11:0] instr_data,
  output logic [3:0]  alu_opcode,
  output logic [3:0]  alu_mio,
  output logic [3:0]  alu_bus_in,
  output logic        alu_oe_n,
  input  logic [3:0]  alu_bus_req,
  input  logic [3:0]  alu_bus_out,
  input  logic        alu_carry,
  input  logic        alu_done,
  input  logic [1:0]  rd_sel,
  output logic [3:0]  rd_data,
`ifdef ALU_SEQ_FLAGS_EN
  output logic        flag_c,
  output logic        flag_z,
`endif
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ERR} state_t;

  localparam logic [4:0] LP_CNT_LAST = 5'(TIMEOUT - 1);

  state_t      r_state;
  logic [11:0] r_instr;
  logic [3:0]  r_regs [4];
  logic [4:0]  r_cnt;
  logic        r_opsel;
  logic        r_ready;
`ifdef ALU_SEQ_FLAGS_EN
  logic        r_flag_c;
  logic        r_flag_z;
`endif

  logic [3:0] w_op;
  logic [1:0] w_rd;
  logic [1:0] w_rs;
  logic [1:0] w_rt;
  logic [3:0] w_imm;
  logic [3:0] w_new_op;
  logic       w_new_legal;
  logic       w_accept;
  logic       w_regreg;
  logic       w_run;

  assign w_op        = r_instr[11:8];
  assign w_rd        = r_instr[7:6];
  assign w_rs        = r_instr[5:4];
  assign w_rt        = r_instr[3:2];
  assign w_imm       = r_instr[3:0];
  assign w_new_op    = instr_data[11:8];
  assign w_new_legal = (w_new_op >= 4'd1) && (w_new_op <= 4'd6);
  assign w_accept    = instr_valid && r_ready;
  assign w_regreg    = (w_op == 4'd2) || (w_op == 4'd4) || (w_op == 4'd5);
  assign w_run       = (r_state == S_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_instr <= '0;
      r_regs  <= '{default: '0};
      r_cnt   <= '0;
      r_opsel <= 1'b0;
      r_ready <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      r_flag_c <= 1'b0;
      r_flag_z <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= !(w_accept && w_new_legal);
          if (w_accept) begin
            r_instr <= instr_data;
            if (w_new_legal) begin
              r_state <= S_RUN;
              r_cnt   <= '0;
              r_opsel <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (alu_done) begin
            r_regs[w_rd] <= alu_bus_out;
            r_state      <= S_IDLE;
            r_ready      <= 1'b1;
`ifdef ALU_SEQ_FLAGS_EN
            r_flag_c <= alu_carry;
            r_flag_z <= (alu_bus_out == 4'd0);
`endif
          end else begin
            // Counter holds cycles already spent; the next one would reach TIMEOUT.
            if (r_cnt == LP_CNT_LAST) begin
              r_state <= S_ERR;
            end else begin
              r_cnt <= r_cnt + 5'd1;
            end
            if (w_regreg && !r_opsel && (alu_bus_req == 4'b0011)) begin
              r_opsel <= 1'b1;
            end
          end
        end
        S_ERR: begin
          r_ready <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Opcode is gated by done combinationally so the ALU never sees a restart.
  assign alu_opcode  = (w_run && !alu_done) ? w_op : '0;
  assign alu_mio     = w_run ? w_imm : '0;
  assign alu_bus_in  = w_run ? (r_opsel ? r_regs[w_rt] : r_regs[w_rs]) : '0;
  assign alu_oe_n    = !w_run;
  assign instr_ready = r_ready;
  assign busy        = (r_state != S_IDLE);
  assign err         = (r_state == S_ERR);
  assign rd_data     = r_regs[rd_sel];

`ifdef ALU_SEQ_FLAGS_EN
  assign flag_c = r_flag_c;
  assign flag_z = r_flag_z;
`else
  logic w_unused_carry;
  assign w_unused_carry = alu_carry;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Scoreboard bench for alu_seq_ctrl with a behavioural ALU model and register-file reference.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [11:0] instr_data = '0;
  logic [3:0]  alu_opcode, alu_mio, alu_bus_in;
  logic        alu_oe_n;
  logic [3:0]  alu_bus_req = '0;
  logic [3:0]  alu_bus_out = '0;
  logic        alu_carry = 1'b0;
  logic        alu_done = 1'b0;
  logic [1:0]  rd_sel = '0;
  logic [3:0]  rd_data;
  logic        busy, err;
`ifdef ALU_SEQ_FLAGS_EN
  logic        flag_c, flag_z;
`endif

  alu_seq_ctrl #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .alu_opcode(alu_opcode), .alu_mio(alu_mio),
    .alu_bus_in(alu_bus_in), .alu_oe_n(alu_oe_n), .alu_bus_req(alu_bus_req),
    .alu_bus_out(alu_bus_out), .alu_carry(alu_carry), .alu_done(alu_done),
    .rd_sel(rd_sel), .rd_data(rd_data),
`ifdef ALU_SEQ_FLAGS_EN
    .flag_c(flag_c), .flag_z(flag_z),
`endif
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Result of an operation as a plain integer, before wrapping to 4 bits.
  function automatic int ref_calc(input int op, input int a, input int b, input int imm);
    case (op)
      1: return a + imm;
      2: return a + b;
      3: return a - imm;
      4: return b - a;
      5: return (~(a & b)) & 15;
      6: return a >> imm;
      default: return 0;
    endcase
  endfunction

  function automatic int carry_of(input int op, input int r);
    if (op == 1 || op == 2) return (r > 15) ? 1 : 0;
    if (op == 3 || op == 4) return (r < 0) ? 1 : 0;
    return 0;
  endfunction

  typedef struct {
    int rd;
    int old_v;
    int new_v;
    int c;
    int z;
  } exp_t;

  exp_t q[$];
  int   ref_r [4] = '{0, 0, 0, 0};
  bit   hang = 1'b0;
  bit   sweep_req = 1'b0;

  // Behavioural ALU: reads operands from the bus, answers with done after the fixed latency.
  bit active = 1'b0;
  int k, a_op, a_imm, op_a, op_b, done_k, res;
  always begin
    @(posedge clk); #1;
    if (!rst_n) begin
      active = 1'b0; alu_done = 1'b0; alu_bus_req = '0; alu_bus_out = '0; alu_carry = 1'b0;
    end else if (!active) begin
      if (alu_opcode != 4'd0) begin
        active = 1'b1; k = 0; a_op = int'(alu_opcode); a_imm = int'(alu_mio);
        done_k = (a_op == 2 || a_op == 4 || a_op == 5) ? 6 : 5;
      end
    end else begin
      k++;
      if (k == 1) begin
        if (done_k == 6) op_a = int'(alu_bus_in);
        alu_bus_req = 4'b0011;
      end else if (k == 2) begin
        alu_bus_req = '0;
        if (done_k == 6) op_b = int'(alu_bus_in);
        else op_a = int'(alu_bus_in);
      end
      if (!hang && k == done_k) begin
        res = ref_calc(a_op, op_a, op_b, a_imm);
        alu_bus_out = 4'(res & 15);
        alu_carry = (carry_of(a_op, res) != 0);
        alu_done = 1'b1;
        #1 chk("opcode_gated_by_done", int'(alu_opcode), 0);
      end else if (k == done_k + 1) begin
        alu_done = 1'b0; alu_bus_out = '0; alu_carry = 1'b0; active = 1'b0;
      end
    end
  end

  // Monitor: pops an expectation on each writeback and checks the register file around it.
  exp_t e;
  always begin
    @(negedge clk);
    if (!busy) begin
      chk("idle_opcode", int'(alu_opcode), 0);
      chk("idle_oe_n", int'(alu_oe_n), 1);
    end
    if (rst_n && busy && alu_done) begin
      if (q.size() == 0) begin
        chk("unexpected_writeback", 1, 0);
      end else begin
        e = q.pop_front();
        rd_sel = 2'(e.rd);
        #1 chk("rd_old_on_write_edge", int'(rd_data), e.old_v);
        @(negedge clk);
        chk("rd_after_write", int'(rd_data), e.new_v);
        chk("ready_after_write", int'(instr_ready), 1);
        chk("idle_after_write", int'(busy), 0);
`ifdef ALU_SEQ_FLAGS_EN
        chk("flag_c", int'(flag_c), e.c);
        chk("flag_z", int'(flag_z), e.z);
`endif
      end
    end else if (sweep_req && !busy) begin
      for (int i = 0; i < 4; i++) begin
        rd_sel = 2'(i);
        #1 chk($sformatf("reg_R%0d", i), int'(rd_data), ref_r[i]);
      end
      sweep_req = 1'b0;
    end
  end

  task automatic issue(input logic [11:0] ins, input bit expect_wb);
    int n = 0;
    int op, rd, rs, rt, imm, r;
    exp_t x;
    @(negedge clk);
    while (!instr_ready && n < 100) begin @(negedge clk); n++; end
    if (!instr_ready) begin
      chk("ready_wait_timeout", 0, 1);
      return;
    end
    instr_valid = 1'b1; instr_data = ins;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    op = int'(ins[11:8]); rd = int'(ins[7:6]); rs = int'(ins[5:4]);
    rt = int'(ins[3:2]); imm = int'(ins[3:0]);
    #1;
    if (op >= 1 && op <= 6) begin
      chk("run_opcode", int'(alu_opcode), op);
      chk("run_mio", int'(alu_mio), imm);
      chk("run_oe_n", int'(alu_oe_n), 0);
      chk("run_ready", int'(instr_ready), 0);
      if (expect_wb) begin
        r = ref_calc(op, ref_r[rs], ref_r[rt], imm);
        x.rd = rd; x.old_v = ref_r[rd]; x.new_v = r & 15;
        x.c = carry_of(op, r); x.z = ((r & 15) == 0) ? 1 : 0;
        q.push_back(x);
        ref_r[rd] = r & 15;
      end
    end else begin
      chk("discard_opcode", int'(alu_opcode), 0);
      chk("discard_busy", int'(busy), 0);
      chk("discard_ready", int'(instr_ready), 1);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || busy || !instr_ready) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("idle_wait_timeout", 0, 1);
  endtask

  task automatic sweep();
    int n = 0;
    wait_idle();
    sweep_req = 1'b1;
    while (sweep_req && n < 50) begin @(posedge clk); n++; end
    if (sweep_req) begin
      chk("sweep_timeout", 0, 1);
      sweep_req = 1'b0;
    end
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  logic [11:0] rins;
  initial begin
    #3;
    chk("rst_ready", int'(instr_ready), 0);
    chk("rst_oe_n", int'(alu_oe_n), 1);
    chk("rst_opcode", int'(alu_opcode), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    release_reset();

    issue({4'd1, 2'd1, 2'd0, 4'd5}, 1'b1);          // ADDI R1 = R0 + 5
    issue({4'd1, 2'd2, 2'd0, 4'd9}, 1'b1);          // ADDI R2 = R0 + 9
    issue({4'd2, 2'd3, 2'd1, 2'd2, 2'd0}, 1'b1);    // ADD  R3 = R1 + R2 = 14
    issue({4'd2, 2'd3, 2'd3, 2'd1, 2'd0}, 1'b1);    // ADD  R3 = R3 + R1 = 3, carry
    issue({4'd4, 2'd0, 2'd2, 2'd1, 2'd0}, 1'b1);    // SUB  R0 = R1 - R2 = C
    issue({4'd5, 2'd0, 2'd1, 2'd2, 2'd0}, 1'b1);    // NAND R0 = ~(R1 & R2) = E
    issue({4'd0, 8'hA5}, 1'b1);
    issue({4'd9, 8'h3C}, 1'b1);
    sweep();

    for (int i = 0; i < 40; i++) begin
      rins = 12'($urandom);
      if ($urandom_range(0, 3) != 0) rins[11:8] = 4'($urandom_range(1, 6));
      issue(rins, 1'b1);
    end
    sweep();

    // Timeout: the ALU never answers.
    ref_r[1] = (ref_r[0] + 3) & 15;
    hang = 1'b1;
    issue({4'd1, 2'd1, 2'd0, 4'd3}, 1'b0);
    repeat (14) @(posedge clk);
    #2;
    chk("err_before_timeout", int'(err), 0);
    @(posedge clk); #2;
    chk("err_at_timeout", int'(err), 1);
    chk("err_opcode", int'(alu_opcode), 0);
    chk("err_ready", int'(instr_ready), 0);
    chk("err_oe_n", int'(alu_oe_n), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_clears_err", int'(err), 0);
    hang = 1'b0;
    ref_r = '{0, 0, 0, 0};
    release_reset();
    sweep();

    // Reset two cycles into a RUN.
    issue({4'd1, 2'd0, 2'd0, 4'd7}, 1'b1);          // R0 = 7
    issue({4'd3, 2'd1, 2'd0, 4'd2}, 1'b0);          // SUBI R1 = R0 - 2, aborted
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_busy", int'(busy), 0);
    chk("async_opcode", int'(alu_opcode), 0);
    chk("async_oe_n", int'(alu_oe_n), 1);
    chk("async_ready", int'(instr_ready), 0);
    chk("async_bus_in", int'(alu_bus_in), 0);
    chk("async_mio", int'(alu_mio), 0);
    ref_r = '{0, 0, 0, 0};
    release_reset();
    sweep();
    issue({4'd6, 2'd2, 2'd3, 4'd1}, 1'b1);          // SHR R2 = R3 >> 1 = 0
    issue({4'd1, 2'd3, 2'd2, 4'd15}, 1'b1);         // ADDI R3 = R2 + 15
    sweep();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
